centroid_tracker: RTL

Downstream consumer of the per-frame centre-of-mass stage. Once per frame it samples the raw centroid (x, y, valid) and gates out outliers. It smooths accepted positions with a shift-based exponential moving average and runs a lock/coast/lost state machine. The overlay/render logic reads the stable, filtered position and lock status from this block instead of the raw, jittery centroid.

---
 rtl/centroid_tracker_if.sv | 24 ++
 rtl/centroid_tracker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/centroid_tracker_if.sv
// Frame-rate centroid bus between the centre-of-mass stage, the tracker
// and the overlay logic. The master drives the raw centroid; the slave
// (the tracker) returns the filtered position and lock status.
interface centroid_tracker_if;
  logic        frame_done_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic        valid_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        locked_out;
  logic        valid_out;
  logic [1:0]  state_out;

  modport master (
    output frame_done_in, x_in, y_in, valid_in,
    input  x_out, y_out, locked_out, valid_out, state_out
  );

  modport slave (
    input  frame_done_in, x_in, y_in, valid_in,
    output x_out, y_out, locked_out, valid_out, state_out
  );
endinterface

// File: rtl/centroid_tracker.sv
// Per-frame centroid tracker: samples the raw centroid on frame_done_in,
// gates outliers against the current filtered position, smooths accepted
// positions with a shift-based EMA and runs SEARCH/ACQUIRE/LOCKED/COAST.
// Fixed latency 2: sample -> diff/gate -> state/filter update.
module centroid_tracker #(
  parameter int SHIFT       = 2,
  parameter int JUMP_MAX    = 64,
  parameter int LOCK_COUNT  = 3,
  parameter int LOST_FRAMES = 8
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  centroid_tracker_if.slave  bus
);
  localparam int STAGES = 2;
  localparam int ACQ_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOST_FRAMES + 1);
  localparam logic [11:0] JMAX_X = 12'(JUMP_MAX);
  localparam logic [10:0] JMAX_Y = 11'(JUMP_MAX);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, COAST} state_t;
  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        vld;
  } meas_t;

  state_t             st, st_n;
  logic [10:0]        fx, fx_n, fx_ema;
  logic [9:0]         fy, fy_n, fy_ema;
  logic [ACQ_W-1:0]   acq, acq_n, acq_inc;
  logic [MISS_W-1:0]  miss, miss_n, miss_inc;
  logic               valid_q, valid_n;
  meas_t              m_q;
  logic [STAGES:1]    vld_pipe;
  logic               armed, accept;
  logic signed [11:0] dx, dx_q;
  logic signed [10:0] dy, dy_q;
  logic [11:0]        adx;
  logic [10:0]        ady;
  logic               gate, gate_q, good;

  // armed is low on the first edge after reset release, so a frame_done_in
  // coinciding with release is dropped; busy while an update is in flight
  assign accept = bus.frame_done_in && armed && !(|vld_pipe);

  // stage 0: capture the raw measurement and launch the valid shift register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      armed    <= 1'b0;
      vld_pipe <= '0;
      m_q      <= '0;
    end else begin
      armed    <= 1'b1;
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) m_q <= '{x: bus.x_in, y: bus.y_in, vld: bus.valid_in};
    end
  end

  // residual against the filter; f is stable while the pipe is busy
  assign dx   = $signed({1'b0, m_q.x}) - $signed({1'b0, fx});
  assign dy   = $signed({1'b0, m_q.y}) - $signed({1'b0, fy});
  assign adx  = dx[11] ? 12'(-dx) : 12'(dx);
  assign ady  = dy[10] ? 11'(-dy) : 11'(dy);
  assign gate = (adx <= JMAX_X) && (ady <= JMAX_Y);

  // stage 1: register residuals and gate decision
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dx_q   <= '0;
      dy_q   <= '0;
      gate_q <= 1'b0;
    end else if (vld_pipe[1]) begin
      dx_q   <= dx;
      dy_q   <= dy;
      gate_q <= gate;
    end
  end

  // floor-shifted step; the result lies between f and m so truncation wraps back in range
  assign fx_ema   = fx + 11'(dx_q >>> SHIFT);
  assign fy_ema   = fy + 10'(dy_q >>> SHIFT);
  assign good     = m_q.vld && gate_q;
  assign acq_inc  = acq + 1'b1;
  assign miss_inc = miss + 1'b1;

  // stage 2 next-state: tracker FSM plus filter/counter updates
  always_comb begin
    st_n   = st;
    fx_n   = fx;
    fy_n   = fy;
    acq_n  = acq;
    miss_n = miss;
    if (vld_pipe[2]) begin
      unique case (st)
        SEARCH: if (m_q.vld) begin
          fx_n   = m_q.x;
          fy_n   = m_q.y;
          acq_n  = ACQ_W'(1);
          miss_n = '0;
          st_n   = (LOCK_COUNT == 1) ? LOCKED : ACQUIRE;
        end
        ACQUIRE: begin
          if (good) begin
            fx_n  = fx_ema;
            fy_n  = fy_ema;
            acq_n = acq_inc;
            if (acq_inc == ACQ_W'(LOCK_COUNT)) st_n = LOCKED;
          end else if (m_q.vld) begin
            fx_n  = m_q.x;
            fy_n  = m_q.y;
            acq_n = ACQ_W'(1);
          end else begin
            acq_n = '0;
            st_n  = SEARCH;
          end
        end
        LOCKED: begin
          if (good) begin
            fx_n   = fx_ema;
            fy_n   = fy_ema;
            miss_n = '0;
          end else if (LOST_FRAMES == 1) begin
            miss_n = '0;
            st_n   = SEARCH;
          end else begin
            miss_n = MISS_W'(1);
            st_n   = COAST;
          end
        end
        COAST: begin
          if (good) begin
            fx_n   = fx_ema;
            fy_n   = fy_ema;
            miss_n = '0;
            st_n   = LOCKED;
          end else if (miss_inc == MISS_W'(LOST_FRAMES)) begin
            miss_n = '0;
            st_n   = SEARCH;
          end else begin
            miss_n = miss_inc;
          end
        end
        default: st_n = SEARCH;
      endcase
    end
    valid_n = vld_pipe[2] && (st_n == LOCKED || st_n == COAST);
  end

  // stage 2 register: state, filter, counters and the output pulse
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      st      <= SEARCH;
      fx      <= '0;
      fy      <= '0;
      acq     <= '0;
      miss    <= '0;
      valid_q <= 1'b0;
    end else begin
      st      <= st_n;
      fx      <= fx_n;
      fy      <= fy_n;
      acq     <= acq_n;
      miss    <= miss_n;
      valid_q <= valid_n;
    end
  end

  assign bus.x_out      = fx;
  assign bus.y_out      = fy;
  assign bus.state_out  = st;
  assign bus.locked_out = (st == LOCKED) || (st == COAST);
  assign bus.valid_out  = valid_q;
endmodule
